// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and codes for the multi-cycle MIPS control unit
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Registered (Moore) control bundle; IRWrite and the fetch PC write are gated separately
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
  } ctrl_t;

  // States that wait on the memory handshake
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - memory wait counter with timeout detect
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic mem_ready,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] count;

  // mem_ready in the final allowed cycle wins over the timeout
  assign expired = active && !mem_ready && (count == LAST);

  // A wait state is only left on mem_ready or expiry, both of which clear the count,
  // so the count is already zero whenever a wait state is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!active || mem_ready || expired) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS main control FSM
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W        = 6,
  parameter int ALUOP_W         = 2,
  parameter int MEM_TIMEOUT     = 16,
  parameter int EN_JUMP         = 1,
  parameter int EN_ADDI         = 1,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               illegal_op,
  output logic               mem_timeout,
  output logic [3:0]         state_o
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl_q;
  logic   illegal_q;
  logic   timeout_q;
  logic   decode_illegal;
  logic   expired;
  logic   fetch_done;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (is_wait_state(state)),
    .mem_ready (mem_ready),
    .expired   (expired)
  );

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = SRCB_FOUR; c.alu_op = ALUOP_ADD; end
      S_DECODE:   begin c.alu_src_b = SRCB_IMM_SH2; c.alu_op = ALUOP_ADD; end
      S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_ADD; end
      S_MEM_RD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEM_WR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_EXEC:     begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_RT; c.alu_op = ALUOP_FUNCT; end
      S_R_WB:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_BRANCH:   begin
        c.alu_src_a = 1'b1; c.alu_src_b = SRCB_RT; c.alu_op = ALUOP_SUB;
        c.pc_write_cond = 1'b1; c.pc_source = PCSRC_ALUOUT;
      end
      S_JUMP:     begin c.pc_write = 1'b1; c.pc_source = PCSRC_JUMP; end
      S_ADDI_EX:  begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_IMM; end
      S_ADDI_WB:  begin c.reg_write = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection from current state, opcode and memory handshake
  always_comb begin
    next_state     = state;
    decode_illegal = 1'b0;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  begin
        if (mem_ready)    next_state = S_DECODE;
        else if (expired) next_state = S_TRAP;
      end
      S_DECODE: begin
        if (Opcode == OPCODE_W'(OP_RTYPE))
          next_state = S_EXEC;
        else if (Opcode == OPCODE_W'(OP_LW) || Opcode == OPCODE_W'(OP_SW))
          next_state = S_MEM_ADDR;
        else if (Opcode == OPCODE_W'(OP_BEQ))
          next_state = S_BRANCH;
        else if ((EN_JUMP != 0) && (Opcode == OPCODE_W'(OP_J)))
          next_state = S_JUMP;
        else if ((EN_ADDI != 0) && (Opcode == OPCODE_W'(OP_ADDI)))
          next_state = S_ADDI_EX;
        else begin
          decode_illegal = 1'b1;
          next_state     = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
        end
      end
      S_MEM_ADDR: next_state = (Opcode == OPCODE_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)    next_state = S_MEM_WB;
        else if (expired) next_state = S_TRAP;
      end
      S_MEM_WR: begin
        if (mem_ready)    next_state = S_FETCH;
        else if (expired) next_state = S_TRAP;
      end
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: next_state = S_FETCH;
      S_EXEC:    next_state = S_R_WB;
      S_ADDI_EX: next_state = S_ADDI_WB;
      S_TRAP:    next_state = S_TRAP;
      default:   next_state = S_IDLE;
    endcase
  end

  // State, registered control outputs (decoded from the state being entered) and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state  <= next_state;
      ctrl_q <= decode_ctrl(next_state);
      if (decode_illegal) illegal_q <= 1'b1;
      if (expired)        timeout_q <= 1'b1;
    end
  end

  // Instruction load and PC+4 happen in the cycle the fetch completes
  assign fetch_done  = (state == S_FETCH) && mem_ready;

  assign PCWrite     = ctrl_q.pc_write | fetch_done;
  assign IRWrite     = fetch_done;
  assign PCWriteCond = ctrl_q.pc_write_cond;
  assign IorD        = ctrl_q.iord;
  assign MemRead     = ctrl_q.mem_read;
  assign MemWrite    = ctrl_q.mem_write;
  assign MemtoReg    = ctrl_q.mem_to_reg;
  assign PCSource    = ctrl_q.pc_source;
  assign ALUOp       = ALUOP_W'(ctrl_q.alu_op);
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign RegWrite    = ctrl_q.reg_write;
  assign RegDst      = ctrl_q.reg_dst;
  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;
  assign state_o     = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

  localparam int TO = 4;

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEM_ADDR = 3, ST_MEM_RD = 4;
  localparam int ST_MEM_WB = 5, ST_MEM_WR = 6, ST_EXEC = 7, ST_R_WB = 8, ST_BRANCH = 9;
  localparam int ST_JUMP = 10, ST_ADDI_EX = 11, ST_ADDI_WB = 12, ST_TRAP = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg, ir_write;
  logic [1:0] pc_source, alu_op, alu_src_b;
  logic       alu_src_a, reg_write, reg_dst, illegal_op, mem_timeout;
  logic [3:0] state_o;

  logic       nop_rst_n = 1'b0;
  logic [5:0] nop_opcode = 6'd0;
  logic       nop_ready = 1'b0;
  logic       n_pcw, n_pcwc, n_iord, n_mr, n_mw, n_m2r, n_irw, n_sa, n_rw, n_rd, n_ill, n_to;
  logic [1:0] n_pcs, n_aop, n_sb;
  logic [3:0] n_state;

  multicycle_control #(.MEM_TIMEOUT(TO), .TRAP_ON_ILLEGAL(1)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pc_write), .PCWriteCond(pc_write_cond), .IorD(iord), .MemRead(mem_read),
    .MemWrite(mem_write), .MemtoReg(mem_to_reg), .IRWrite(ir_write), .PCSource(pc_source),
    .ALUOp(alu_op), .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .RegWrite(reg_write),
    .RegDst(reg_dst), .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state_o(state_o)
  );

  multicycle_control #(.MEM_TIMEOUT(TO), .TRAP_ON_ILLEGAL(0)) dut_nop (
    .clk(clk), .rst_n(nop_rst_n), .Opcode(nop_opcode), .mem_ready(nop_ready),
    .PCWrite(n_pcw), .PCWriteCond(n_pcwc), .IorD(n_iord), .MemRead(n_mr),
    .MemWrite(n_mw), .MemtoReg(n_m2r), .IRWrite(n_irw), .PCSource(n_pcs),
    .ALUOp(n_aop), .ALUSrcA(n_sa), .ALUSrcB(n_sb), .RegWrite(n_rw),
    .RegDst(n_rd), .illegal_op(n_ill), .mem_timeout(n_to), .state_o(n_state)
  );

  wire [15:0] ctrl_vec = {pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg,
                          ir_write, pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst};

  int tests = 0;
  int fails = 0;
  logic [1:0] exp_flags = 2'b00;

  typedef struct {
    int st;
    bit rdy;
  } step_t;
  step_t plan[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control outputs each state must show, taken from the state table
  function automatic logic [15:0] exp_ctrl(input int st, input bit rdy);
    logic pcw, pcwc, io, mr, mw, m2r, irw, sa, rw, rd;
    logic [1:0] pcs, aop, sb;
    pcw = 0; pcwc = 0; io = 0; mr = 0; mw = 0; m2r = 0; irw = 0; sa = 0; rw = 0; rd = 0;
    pcs = 2'b00; aop = 2'b00; sb = 2'b00;
    case (st)
      ST_FETCH:    begin mr = 1; sb = 2'b01; pcw = rdy; irw = rdy; end
      ST_DECODE:   sb = 2'b11;
      ST_MEM_ADDR: begin sa = 1; sb = 2'b10; end
      ST_MEM_RD:   begin mr = 1; io = 1; end
      ST_MEM_WB:   begin rw = 1; m2r = 1; end
      ST_MEM_WR:   begin mw = 1; io = 1; end
      ST_EXEC:     begin sa = 1; aop = 2'b10; end
      ST_R_WB:     begin rw = 1; rd = 1; end
      ST_BRANCH:   begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      ST_JUMP:     begin pcw = 1; pcs = 2'b10; end
      ST_ADDI_EX:  begin sa = 1; sb = 2'b10; aop = 2'b11; end
      ST_ADDI_WB:  rw = 1;
      default:     ;
    endcase
    return {pcw, pcwc, io, mr, mw, m2r, irw, pcs, aop, sa, sb, rw, rd};
  endfunction

  function automatic logic [5:0] op_of(input int kind);
    case (kind)
      0: return 6'b000000;
      1: return 6'b100011;
      2: return 6'b101011;
      3: return 6'b000100;
      4: return 6'b000010;
      default: return 6'b001000;
    endcase
  endfunction

  task automatic push_fixed(input int st, input int n, input bit rdy);
    for (int i = 0; i < n; i++) plan.push_back('{st: st, rdy: rdy});
  endtask

  task automatic push_one(input int st);
    plan.push_back('{st: st, rdy: 1'($urandom_range(0, 1))});
  endtask

  // A memory state held for 'waits' not-ready cycles, then one ready cycle
  task automatic push_wait(input int st, input int waits);
    push_fixed(st, waits, 1'b0);
    push_fixed(st, 1, 1'b1);
  endtask

  task automatic build_instr(input int kind, input int wf, input int wm);
    push_wait(ST_FETCH, wf);
    push_one(ST_DECODE);
    case (kind)
      0: begin push_one(ST_EXEC); push_one(ST_R_WB); end
      1: begin push_one(ST_MEM_ADDR); push_wait(ST_MEM_RD, wm); push_one(ST_MEM_WB); end
      2: begin push_one(ST_MEM_ADDR); push_wait(ST_MEM_WR, wm); end
      3: push_one(ST_BRANCH);
      4: push_one(ST_JUMP);
      default: begin push_one(ST_ADDI_EX); push_one(ST_ADDI_WB); end
    endcase
  endtask

  // Called at #1 after a rising edge; drives each planned cycle and checks it mid-cycle
  task automatic run_plan();
    foreach (plan[i]) begin
      mem_ready = plan[i].rdy;
      @(negedge clk);
      chk("state", 32'(state_o), 32'(plan[i].st));
      chk("ctrl", 32'(ctrl_vec), 32'(exp_ctrl(plan[i].st, plan[i].rdy)));
      chk("flags", 32'({illegal_op, mem_timeout}), 32'(exp_flags));
      @(posedge clk);
      #1;
    end
    plan.delete();
  endtask

  // Leaves the DUT in its first FETCH cycle, at #1 after the edge
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    exp_flags = 2'b00;
    @(posedge clk);
    #1;
    chk("rst_state", 32'(state_o), 32'(ST_IDLE));
    chk("rst_ctrl", 32'(ctrl_vec), 32'd0);
    chk("rst_flags", 32'({illegal_op, mem_timeout}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("idle_after_release", 32'(state_o), 32'(ST_IDLE));
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // Directed: R-type with zero waits, lw with 3 memory waits, beq then j
    opcode = op_of(0); build_instr(0, 0, 0); run_plan();
    opcode = op_of(1); build_instr(1, 0, 3); run_plan();
    opcode = op_of(3); build_instr(3, 0, 0); run_plan();
    opcode = op_of(4); build_instr(4, 0, 0); run_plan();
    // mem_ready on the last allowed fetch cycle wins over the timeout
    opcode = op_of(0); build_instr(0, TO - 1, 0); run_plan();

    // Random legal instruction stream with waits below the timeout
    repeat (40) begin
      int kind;
      kind = int'($urandom_range(0, 5));
      opcode = op_of(kind);
      build_instr(kind, int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)));
      run_plan();
    end

    // Illegal opcode traps and stays trapped
    opcode = 6'b111111;
    push_wait(ST_FETCH, 0);
    push_one(ST_DECODE);
    run_plan();
    exp_flags = 2'b10;
    for (int i = 0; i < 5; i++) push_one(ST_TRAP);
    run_plan();
    do_reset();

    // Fetch timeout
    push_fixed(ST_FETCH, TO, 1'b0);
    run_plan();
    exp_flags = 2'b01;
    for (int i = 0; i < 3; i++) push_one(ST_TRAP);
    run_plan();
    do_reset();

    // Load data timeout
    opcode = op_of(1);
    push_wait(ST_FETCH, 0);
    push_one(ST_DECODE);
    push_one(ST_MEM_ADDR);
    push_fixed(ST_MEM_RD, TO, 1'b0);
    run_plan();
    exp_flags = 2'b01;
    for (int i = 0; i < 2; i++) push_one(ST_TRAP);
    run_plan();
    do_reset();

    // Reset pulse in the middle of a store wait
    opcode = op_of(2);
    push_wait(ST_FETCH, 0);
    push_one(ST_DECODE);
    push_one(ST_MEM_ADDR);
    push_fixed(ST_MEM_WR, 2, 1'b0);
    run_plan();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("memwrite_before_rst", 32'(mem_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("memwrite_after_rst", 32'(mem_write), 32'd0);
    chk("state_after_rst", 32'(state_o), 32'(ST_IDLE));
    chk("ctrl_after_rst", 32'(ctrl_vec), 32'd0);
    do_reset();
    opcode = op_of(0); build_instr(0, 0, 0); run_plan();

    // Illegal opcode executed as a NOP when trapping is disabled
    chk("nop_rst_state", 32'(n_state), 32'(ST_IDLE));
    @(negedge clk);
    nop_rst_n = 1'b1;
    nop_ready = 1'b1;
    nop_opcode = 6'b111111;
    @(posedge clk); #1;
    chk("nop_fetch", 32'(n_state), 32'(ST_FETCH));
    chk("nop_irwrite", 32'(n_irw), 32'd1);
    @(posedge clk); #1;
    chk("nop_decode", 32'(n_state), 32'(ST_DECODE));
    chk("nop_flag_pre", 32'(n_ill), 32'd0);
    @(posedge clk); #1;
    chk("nop_back_fetch", 32'(n_state), 32'(ST_FETCH));
    chk("nop_flags", 32'({n_ill, n_to}), 32'(2'b10));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle MIPS main control unit, the next generation of the single-cycle opcode decoder. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives the shared-datapath control signals (PC, IR, ALU source muxes, memory, register file). It also handles variable-latency memory through a mem_ready handshake, with timeout and illegal-opcode trapping. It sits between the instruction register opcode field and the multi-cycle datapath.

Parameters:
OPCODE_W, 6, opcode field width.
ALUOP_W, 2, ALUOp width to the ALU control block (00 add, 01 sub, 10 funct, 11 addi/imm).
MEM_TIMEOUT, 16, maximum wait cycles for mem_ready in one memory state; must be at least 1.
EN_JUMP, 1, when 1, the j opcode (000010) is decoded; when 0, it is treated as illegal.
EN_ADDI, 1, when 1, the addi opcode (001000) is decoded; when 0, it is treated as illegal.
TRAP_ON_ILLEGAL, 1, when 1, an illegal opcode enters TRAP; when 0, it is executed as a NOP (return to FETCH).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
Opcode  in  OPCODE_W  IR[31:26], valid from DECODE onward
mem_ready  in  1  memory completes the current access this cycle
PCWrite  out  1  unconditional PC write
PCWriteCond  out  1  PC write if ALU zero
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
MemtoReg  out  1  writeback data select: 1 = MDR
IRWrite  out  1  instruction register load
PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
ALUOp  out  ALUOP_W  ALU operation class
ALUSrcA  out  1  0 = PC, 1 = rs
ALUSrcB  out  2  00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2
RegWrite  out  1  register file write
RegDst  out  1  destination register select: 1 = rd
illegal_op  out  1  sticky flag: illegal opcode trapped
mem_timeout  out  1  sticky flag: memory wait expired
state_o  out  4  current state encoding, for debug

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, wait counter = 0, both sticky flags = 0. Every control output is 0 in IDLE.
- IDLE moves to FETCH on the first clock after reset is released.
- Encoding: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12, TRAP=15.
- Any output not listed for a state is 0.
- FETCH: MemRead=1, ALUSrcB=01, ALUOp=00.
  - IRWrite and PCWrite are driven as mem_ready (a registered-free gate). This is the only Mealy term.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 000000 goes to EXEC.
  - 100011 and 101011 go to MEM_ADDR.
  - 000100 goes to BRANCH.
  - 000010 goes to JUMP if EN_JUMP.
  - 001000 goes to ADDI_EX if EN_ADDI.
  - Any other opcode: set illegal_op and go to TRAP if TRAP_ON_ILLEGAL, else go to FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead=1, IorD=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEM_WR: MemWrite=1, IorD=1. Waits for mem_ready, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to R_WB.
- R_WB: RegWrite=1, RegDst=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Goes to ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0. Goes to FETCH.
- Opcode is sampled combinationally in DECODE and MEM_ADDR only. The datapath holds the IR stable from FETCH onward.
- Wait counter (FETCH, MEM_RD, MEM_WR):
  - Clears on entry to a wait state and on mem_ready.
  - Increments each cycle without mem_ready.
  - When the count reaches MEM_TIMEOUT-1 and mem_ready is still low: set mem_timeout and go to TRAP.
  - If mem_ready arrives in that same cycle, it wins: no timeout.
- TRAP: all outputs 0; stays in TRAP until reset.
- Cycle counts with zero wait: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
- Each memory wait cycle adds 1.
- Reset asserted mid-instruction: immediate return to IDLE; no write strobe may be asserted after rst_n falls.

Decomposition:
- Shared package (mips_ctrl_pkg):
  - state enum and encodings;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - ALUOp codes;
  - PCSource and ALUSrcB select codes.
- One natural sub-module: mem_wait_timer (counter plus timeout compare, parametrised by MEM_TIMEOUT).
- Next-state logic and output decode stay in multicycle_control.

Test Plan:
- Reset: hold rst_n=0, then release → IDLE with all outputs 0; state_o 0 → 1 on the first edge; MemRead=1 in FETCH.
- R-type, Opcode=000000, mem_ready=1 throughout → state sequence 1,2,7,8,1; RegWrite=1 and RegDst=1 only in state 8; total 4 cycles.
- lw, Opcode=100011, mem_ready low for 3 cycles in MEM_RD → MEM_RD held 4 cycles; MEM_WB has RegWrite=1 and MemtoReg=1; IRWrite=0 throughout.
- beq (000100) then j (000010) → BRANCH: PCWriteCond=1, PCSource=01, ALUOp=01. JUMP: PCWrite=1, PCSource=10. Each instruction takes 3 cycles.
- Illegal Opcode=111111: with TRAP_ON_ILLEGAL=1 → TRAP (15), illegal_op=1, held until rst_n. With 0 → return to FETCH, illegal_op=1.
- mem_ready held low in FETCH with MEM_TIMEOUT=4 → mem_timeout=1 and TRAP after 4 cycles. Second case: mem_ready in the 4th cycle → DECODE, no timeout. Third case: rst_n pulse mid-MEM_WR → MemWrite drops immediately, state 0.
